// File: rtl/wb_packer.sv
// Write-back packer: collects signed result elements into one memory word and writes it out with a handshake.
// Optional macro WB_RELU_EN clamps negative elements to zero as they are captured.
module wb_packer #(
  parameter int                DATA_W    = 16,
  parameter int                ELEMS     = 4,
  parameter int                ADDR_W    = 10,
  parameter logic [ADDR_W-1:0] BASE_ADDR = {ADDR_W{1'b0}}
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     init,
  input  logic                     ldWR,
  input  logic                     lastWR,
  input  logic                     rstWR,
  input  logic                     weMem,
  input  logic [DATA_W-1:0]        dataIn,
  input  logic                     memAck,
  output logic                     fullWR,
  output logic                     memWE,
  output logic [ADDR_W-1:0]        memAdr,
  output logic [DATA_W*ELEMS-1:0]  memData,
  output logic                     busy,
  output logic                     ovf
);

  localparam int CNT_W = $clog2(ELEMS + 1);

  typedef enum logic [1:0] {FILL = 2'd0, WRITE = 2'd1, WAIT = 2'd2} state_t;

  state_t                         state_r, nextState_s;
  logic [CNT_W-1:0]               cnt_r, cnt_s;
  logic [ELEMS-1:0][DATA_W-1:0]   slots_r, slots_s;
  logic                           fullWR_r, full_s;
  logic                           memWE_r, we_s;
  logic                           busy_r, busy_s;
  logic                           ovf_r, ovf_s;
  logic [ADDR_W-1:0]              adr_r, adr_s;
  logic                           ldErr_s, weErr_s, busyErr_s;

  function automatic logic [DATA_W-1:0] capture(input logic [DATA_W-1:0] v);
`ifdef WB_RELU_EN
    if (v[DATA_W-1]) begin
      capture = {DATA_W{1'b0}};
    end else begin
      capture = v;
    end
`else
    capture = v;
`endif
  endfunction

  // Next-state and next-output computation for the fill/write/wait sequence
  always_comb begin
    nextState_s = state_r;
    cnt_s       = cnt_r;
    slots_s     = slots_r;
    full_s      = fullWR_r;
    adr_s       = adr_r;
    we_s        = 1'b0;
    busy_s      = busy_r;
    ldErr_s     = 1'b0;
    weErr_s     = 1'b0;
    busyErr_s   = 1'b0;
    case (state_r)
      FILL: begin
        if (init) begin
          adr_s   = BASE_ADDR;
          cnt_s   = {CNT_W{1'b0}};
          slots_s = {(DATA_W*ELEMS){1'b0}};
          full_s  = 1'b0;
        end else if (rstWR) begin
          // rstWR also swallows a same-cycle weMem without flagging it
          cnt_s   = {CNT_W{1'b0}};
          slots_s = {(DATA_W*ELEMS){1'b0}};
          full_s  = 1'b0;
        end else begin
          if (ldWR) begin
            if (fullWR_r) begin
              ldErr_s = 1'b1;
            end else begin
              for (int i = 0; i < ELEMS; i++) begin
                if (cnt_r == CNT_W'(i)) begin
                  slots_s[i] = capture(dataIn);
                end else begin
                  slots_s[i] = slots_r[i];
                end
              end
              cnt_s  = cnt_r + CNT_W'(1);
              full_s = (cnt_r == CNT_W'(ELEMS - 1)) || lastWR;
            end
          end else begin
            ldErr_s = 1'b0;
          end
          if (weMem) begin
            if (fullWR_r) begin
              nextState_s = WRITE;
              we_s        = 1'b1;
              busy_s      = 1'b1;
            end else begin
              weErr_s = 1'b1;
            end
          end else begin
            weErr_s = 1'b0;
          end
        end
      end
      WRITE, WAIT: begin
        busyErr_s = ldWR | weMem | rstWR | init;
        if (memAck) begin
          nextState_s = FILL;
          adr_s       = adr_r + ADDR_W'(1);
          cnt_s       = {CNT_W{1'b0}};
          slots_s     = {(DATA_W*ELEMS){1'b0}};
          full_s      = 1'b0;
          busy_s      = 1'b0;
        end else begin
          nextState_s = WAIT;
        end
      end
      default: begin
        nextState_s = FILL;
        busy_s      = 1'b0;
      end
    endcase
    ovf_s = ovf_r | ldErr_s | weErr_s | busyErr_s;
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= FILL;
      cnt_r    <= {CNT_W{1'b0}};
      slots_r  <= {(DATA_W*ELEMS){1'b0}};
      fullWR_r <= 1'b0;
      memWE_r  <= 1'b0;
      busy_r   <= 1'b0;
      ovf_r    <= 1'b0;
      adr_r    <= BASE_ADDR;
    end else begin
      state_r  <= nextState_s;
      cnt_r    <= cnt_s;
      slots_r  <= slots_s;
      fullWR_r <= full_s;
      memWE_r  <= we_s;
      busy_r   <= busy_s;
      ovf_r    <= ovf_s;
      adr_r    <= adr_s;
    end
  end

  assign fullWR  = fullWR_r;
  assign memWE   = memWE_r;
  assign memAdr  = adr_r;
  assign memData = slots_r;
  assign busy    = busy_r;
  assign ovf     = ovf_r;

endmodule
